// File: rtl/spc_call_ctrl.sv
// Call/return sequencer for the special register file: pushes or pops LR through
// one data-memory port, then writes SP/LR/PC together in a single UPDATE cycle.
module spc_call_ctrl #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [31:0] target_addr,
    input  logic [31:0] re_sp,
    input  logic [31:0] re_lr,
    input  logic [31:0] re_pc,
    output logic        wr_sp,
    output logic [31:0] wr_sp_data,
    output logic        wr_lr,
    output logic [31:0] wr_lr_data,
    output logic        wr_pc,
    output logic [31:0] wr_pc_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CALL_PUSH = 3'd1,
        S_RET_POP   = 3'd2,
        S_UPDATE    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] sp_q, sp_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pop_q, pop_d;
    logic        is_call_q, is_call_d;
    logic        err_q, err_d;

    logic [31:0] re_sp_m4;
    logic [31:0] sp_m4;
    logic [7:0]  cnt_inc;

    assign re_sp_m4 = re_sp - 32'd4;
    assign sp_m4    = sp_q - 32'd4;
    assign cnt_inc  = cnt_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            sp_q      <= 32'd0;
            lr_q      <= 32'd0;
            pc_q      <= 32'd0;
            tgt_q     <= 32'd0;
            pop_q     <= 32'd0;
            is_call_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sp_q      <= sp_d;
            lr_q      <= lr_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            pop_q     <= pop_d;
            is_call_q <= is_call_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sp_d      = sp_q;
        lr_d      = lr_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pop_d     = pop_q;
        is_call_d = is_call_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                // call wins; a simultaneous return request is simply not seen
                if (call_req) begin
                    sp_d      = re_sp;
                    lr_d      = re_lr;
                    pc_d      = re_pc;
                    tgt_d     = target_addr;
                    is_call_d = 1'b1;
                    if (target_addr[1:0] != 2'b00 || re_sp < 32'd4 || re_sp_m4 < STACK_LIMIT) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_CALL_PUSH;
                        err_d   = 1'b0;
                    end
                end else if (ret_req) begin
                    sp_d      = re_sp;
                    lr_d      = re_lr;
                    pc_d      = re_pc;
                    tgt_d     = target_addr;
                    is_call_d = 1'b0;
                    if (re_sp >= STACK_BASE) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RET_POP;
                        err_d   = 1'b0;
                    end
                end
            end
            S_CALL_PUSH, S_RET_POP: begin
                // an ack in the expiry cycle still counts as success
                if (mem_ack) begin
                    if (state_q == S_RET_POP) begin
                        pop_d = mem_rdata;
                    end
                    state_d = S_UPDATE;
                    cnt_d   = 8'd0;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_UPDATE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_sp      = 1'b0;
        wr_sp_data = 32'd0;
        wr_lr      = 1'b0;
        wr_lr_data = 32'd0;
        wr_pc      = 1'b0;
        wr_pc_data = 32'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_CALL_PUSH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m4;
                mem_wdata = lr_q;
            end
            S_RET_POP: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
            end
            S_UPDATE: begin
                wr_sp = 1'b1;
                wr_lr = 1'b1;
                wr_pc = 1'b1;
                if (is_call_q) begin
                    wr_sp_data = sp_m4;
                    wr_lr_data = pc_q + 32'd4;
                    wr_pc_data = tgt_q;
                end else begin
                    wr_sp_data = sp_q + 32'd4;
                    wr_lr_data = pop_q;
                    wr_pc_data = lr_q;
                end
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_spc_call_ctrl.sv
// Bench for spc_call_ctrl: directed call/return vectors with a scoreboard of
// expected memory requests, register updates and completions.
module tb_spc_call_ctrl;

    localparam int W = 98;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [31:0] target_addr = 32'd0;
    logic [31:0] re_sp = 32'd0;
    logic [31:0] re_lr = 32'd0;
    logic [31:0] re_pc = 32'd0;
    logic        wr_sp, wr_lr, wr_pc;
    logic [31:0] wr_sp_data, wr_lr_data, wr_pc_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        busy, done, err;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    logic req_prev = 1'b0;

    spc_call_ctrl #(
        .STACK_BASE (32'h0000_1000),
        .STACK_LIMIT(32'h0000_0800),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .call_req(call_req), .ret_req(ret_req), .target_addr(target_addr),
        .re_sp(re_sp), .re_lr(re_lr), .re_pc(re_pc),
        .wr_sp(wr_sp), .wr_sp_data(wr_sp_data),
        .wr_lr(wr_lr), .wr_lr_data(wr_lr_data),
        .wr_pc(wr_pc), .wr_pc_data(wr_pc_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic sb_pop(input string nm, input logic [W-1:0] got);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s unexpected event got=%h expected=none", nm, got);
        end else begin
            check(nm, got, exp_q.pop_front());
        end
    endtask

    function automatic logic [W-1:0] ev_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        return {2'd0, 31'd0, we, addr, (we ? wd : 32'd0)};
    endfunction

    function automatic logic [W-1:0] ev_upd(input logic [31:0] sp, input logic [31:0] lr, input logic [31:0] pc);
        return {2'd1, sp, lr, pc};
    endfunction

    function automatic logic [W-1:0] ev_done(input logic e);
        return {2'd2, 31'd0, e, 64'd0};
    endfunction

    // monitor: samples on the falling edge, compares against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            req_prev = 1'b0;
        end else begin
            if (mem_req && !req_prev)
                sb_pop("mem_request", ev_mem(mem_we, mem_addr, mem_wdata));
            if (wr_sp || wr_lr || wr_pc) begin
                check("strobes_together", W'({wr_sp, wr_lr, wr_pc}), W'(3'b111));
                sb_pop("reg_update", ev_upd(wr_sp_data, wr_lr_data, wr_pc_data));
            end
            if (done)
                sb_pop("done", ev_done(err));
            if (err)
                check("err_only_with_done", W'(done), W'(1'b1));
            req_prev = mem_req;
        end
    end

    // driver: one operation; ack_at = mem_req cycle carrying the ack (0 = never)
    task automatic run_op(
        input int id, input bit c, input bit r,
        input logic [31:0] sp, input logic [31:0] lr, input logic [31:0] pc,
        input logic [31:0] tgt, input logic [31:0] rdata, input int ack_at,
        input bit e_mem, input bit e_we, input logic [31:0] e_addr, input logic [31:0] e_wd,
        input bit e_upd, input logic [31:0] e_sp, input logic [31:0] e_lr, input logic [31:0] e_pc,
        input bit e_err, input int e_done, input int e_req);
        int cyc;
        int n_req;
        bit seen;
        if (e_mem) exp_q.push_back(ev_mem(e_we, e_addr, e_wd));
        if (e_upd) exp_q.push_back(ev_upd(e_sp, e_lr, e_pc));
        exp_q.push_back(ev_done(e_err));
        call_req = c; ret_req = r;
        re_sp = sp; re_lr = lr; re_pc = pc; target_addr = tgt;
        @(posedge clk); #1;
        // later input changes must not affect the accepted operation
        re_sp = 32'h0000_0500; re_lr = $urandom; re_pc = $urandom; target_addr = $urandom;
        cyc = 0; n_req = 0; seen = 0;
        while (cyc < 40) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (mem_req) n_req++;
            mem_ack = mem_req && (n_req == ack_at);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(posedge clk); #1;
            cyc++;
            mem_ack = 1'b0;
        end
        call_req = 1'b0; ret_req = 1'b0;
        check($sformatf("op%0d_done_seen", id), W'(seen), W'(1'b1));
        check($sformatf("op%0d_done_latency", id), W'(cyc), W'(e_done));
        check($sformatf("op%0d_mem_req_cycles", id), W'(n_req), W'(e_req));
        @(posedge clk); #1;
        check($sformatf("op%0d_idle_after", id), W'(busy), W'(1'b0));
    endtask

    initial begin
        #12;
        total++;
        if ({busy, done, err, mem_req, mem_we, wr_sp, wr_lr, wr_pc} !== 8'd0 ||
            {mem_addr, mem_wdata, wr_sp_data, wr_lr_data, wr_pc_data} !== 160'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b addr=%h wsp=%h expected all zero",
                     busy, done, mem_addr, wr_sp_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", W'(busy), W'(1'b0));

        // call then matching return
        run_op(1, 1, 0, 32'h1000, 32'h40, 32'h100, 32'h200, 32'h0, 3,
               1, 1, 32'hFFC, 32'h40, 1, 32'hFFC, 32'h104, 32'h200, 0, 4, 3);
        run_op(2, 0, 1, 32'hFFC, 32'h104, 32'h200, 32'h0, 32'h40, 2,
               1, 0, 32'hFFC, 32'h0, 1, 32'h1000, 32'h40, 32'h104, 0, 3, 2);
        // bounds errors
        run_op(3, 1, 0, 32'h800, 32'h40, 32'h100, 32'h200, 32'h0, 1,
               0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run_op(4, 0, 1, 32'h1000, 32'h40, 32'h100, 32'h0, 32'h0, 1,
               0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run_op(5, 1, 0, 32'h1000, 32'h40, 32'h100, 32'h202, 32'h0, 1,
               0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run_op(6, 1, 0, 32'h804, 32'h1, 32'h8, 32'h300, 32'h0, 1,
               1, 1, 32'h800, 32'h1, 1, 32'h800, 32'hC, 32'h300, 0, 2, 1);
        run_op(7, 1, 0, 32'h2, 32'h1, 32'h8, 32'h0, 32'h0, 1,
               0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        // timeouts, then ack exactly at expiry
        run_op(8, 1, 0, 32'h1000, 32'h77, 32'h100, 32'h200, 32'h0, 0,
               1, 1, 32'hFFC, 32'h77, 0, 32'h0, 32'h0, 32'h0, 1, 4, 4);
        run_op(9, 0, 1, 32'hFF0, 32'h77, 32'h100, 32'h0, 32'h0, 0,
               1, 0, 32'hFF0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 4, 4);
        run_op(10, 1, 0, 32'hF00, 32'hAAAA_0000, 32'hFFFF_FFFC, 32'h10, 32'h0, 4,
               1, 1, 32'hEFC, 32'hAAAA_0000, 1, 32'hEFC, 32'h0, 32'h10, 0, 5, 4);
        // simultaneous requests: call wins
        run_op(11, 1, 1, 32'h1000, 32'h40, 32'h100, 32'h200, 32'h0, 2,
               1, 1, 32'hFFC, 32'h40, 1, 32'hFFC, 32'h104, 32'h200, 0, 3, 2);
        run_op(12, 0, 1, 32'hFFC, 32'h104, 32'h200, 32'h0, 32'h1234_5678, 4,
               1, 0, 32'hFFC, 32'h0, 1, 32'h1000, 32'h1234_5678, 32'h104, 0, 5, 4);
        run_op(13, 0, 1, 32'h0, 32'h8, 32'h20, 32'h0, 32'h9, 1,
               1, 0, 32'h0, 32'h0, 1, 32'h4, 32'h9, 32'h8, 0, 2, 1);

        // stray ack while idle is ignored
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("stray_ack_busy", W'(busy), W'(1'b0));
        check("stray_ack_req", W'(mem_req), W'(1'b0));

        // async reset in the middle of CALL_PUSH
        exp_q.push_back(ev_mem(1'b1, 32'hFFC, 32'h40));
        call_req = 1'b1; re_sp = 32'h1000; re_lr = 32'h40; re_pc = 32'h100; target_addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_req", W'(mem_req), W'(1'b1));
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("midreset_req", W'(mem_req), W'(1'b0));
        check("midreset_busy", W'(busy), W'(1'b0));
        check("midreset_strobes", W'({wr_sp, wr_lr, wr_pc, done, err}), W'(5'd0));
        check("midreset_addr", W'(mem_addr), W'(32'd0));
        exp_q.delete();
        call_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", W'(busy), W'(1'b0));
        run_op(14, 1, 0, 32'h1000, 32'h40, 32'h100, 32'h200, 32'h0, 3,
               1, 1, 32'hFFC, 32'h40, 1, 32'hFFC, 32'h104, 32'h200, 0, 4, 3);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
